multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Moore-style control FSM that sequences a multi-cycle MIPS datapath: shared memory for instructions and data, registered IR/ALUOut/MDR, and one ALU reused for PC increment, branch target and execute. Decodes the same instruction subset as the single-cycle core: add(u), sub(u), and, or, xor, nor, slt, sltu, beq, bne, lw, sw, addi(u), slti, sltiu, andi, ori, xori, lui. Emits the per-cycle datapath controls, a retired-instruction counter and a sticky illegal-instruction flag.

## Interface
- No parameters.
- Reset is synchronous and active-high on `reset`; there is one clock, `clk`.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state below.
- op  in  6  IR[31:26], stable from DECODE onward.
- func  in  6  IR[5:0].
- AluZero  in  1  ALU zero flag, same cycle.
- PCWrite  out  1  load PC.
- PCSrc  out  1  0: ALU result, 1: ALUOut (branch target).
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load IR from memory read data.
- RegDst  out  1  1: rd, 0: rt.
- MemtoReg  out  1  1: MDR, 0: ALUOut.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  1  0: PC, 1: RD1 register.
- ALUSrcB  out  2  00 RD2 reg, 01 constant 4, 10 Imm32, 11 Imm32<<2.
- SZEn  out  1  1 sign-extend, 0 zero-extend imm.
- AluOP  out  4  ADD 0, SUB 1, SLT 2, SLTU 3, AND 4, OR 5, NOR 6, XOR 7, LUI 8.
- retired  out  32  instructions completed since reset.
- illegal  out  1  sticky: unsupported op/func decoded.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, AluOP=ADD, PCSrc=0, PCWrite=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, SZEn=1, AluOP=ADD (ALUOut <= branch target). Next: lw/sw -> MEMADR; R-type with legal func -> EXEC_R; beq/bne -> BRANCH; legal I-ALU -> EXEC_I; else -> FETCH with illegal set.
- MEMADR: ALUSrcA=1, ALUSrcB=10, SZEn=1, ADD -> MEMRD (lw) / MEMWR (sw).
- MEMRD: IorD=1 -> MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, AluOP from func (add/addu ADD, sub/subu SUB, and, or, xor, nor, slt, sltu) -> ALUWB, RegDst=1.
- EXEC_I: ALUSrcA=1, ALUSrcB=10; addi/addiu/slti/sltiu SZEn=1, andi/ori/xori SZEn=0, lui SZEn=x; AluOP ADD/ADD/SLT/SLTU/AND/OR/XOR/LUI -> ALUWB, RegDst=0.
- ALUWB: MemtoReg=0, RegWrite=1, RegDst held per class -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=1; PCWrite = (beq & AluZero) | (bne & ~AluZero) -> FETCH.
- All write enables (PCWrite, IRWrite, MemWrite, RegWrite) are 0 in any state not listed as asserting them; don't-care muxes are driven 0, never x.
- retired increments by 1 on the final cycle of each legal instruction (MEMWB, MEMWR, ALUWB, BRANCH); wraps 0xFFFFFFFF -> 0.
- Illegal decode: no register, memory or PC write beyond FETCH's PC+4; retired unchanged; illegal stays 1 until reset.

## Timing
- Outputs are combinational from the state register, plus op/func/AluZero; there are no output registers.
- Cycles per instruction: branch 3, R-type/I-ALU/sw 4, lw 5, illegal 2.
- Reset: in the cycle reset is sampled high, all write enables are forced 0. Next state is FETCH, with retired=0 and illegal=0. This applies from any state, including mid-instruction; for example, reset in MEMWR suppresses the store.
- The first edge with reset low executes FETCH.
- op/func are sampled only from DECODE onward. The IR update in FETCH does not affect FETCH outputs.

## Test plan
- Reset, then `addi $1,$0,5` (0x20010005) -> FETCH, DECODE, EXEC_I, ALUWB. RegWrite=1 only in cycle 4 with RegDst=0, SZEn=1. retired=1.
- `lw` (0x8C220004) -> 5 cycles. IorD=1 in MEMRD. MemtoReg=RegWrite=1 in MEMWB. retired +1.
- beq with AluZero=1, then with AluZero=0 in BRANCH -> PCWrite=1 and PCSrc=1 in the first case; PCWrite=0 in the second. Both take 3 cycles.
- func=0x3F R-type, then op=0x3F -> each returns to FETCH after DECODE with no writes. illegal=1 persists; retired unchanged.
- Reset asserted in MEMWR of a sw -> MemWrite=0 that cycle, next state FETCH, retired=0.
- Preload retired to 0xFFFFFFFF via force, then retire one `ori` -> retired=0, with SZEn=0 and AluOP=5 in EXEC_I.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS datapath with shared instruction/data memory.
// Datapath controls decode from the state register plus op/func/AluZero; retired and illegal are registered.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        AluZero,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        SZEn,
    output logic [3:0]  AluOP,
    output logic [31:0] retired,
    output logic        illegal
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned CNT_W  = 32;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
    localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
    localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OP_W-1:0] FN_AND  = 6'h24;
    localparam logic [OP_W-1:0] FN_OR   = 6'h25;
    localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
    localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
    localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;
    localparam logic [OP_W-1:0] FN_SLTU = 6'h2B;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd3;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_LUI  = 4'd8;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t state, state_next;

    logic             is_rtype;
    logic             is_mem;
    logic             is_branch;
    logic             r_legal;
    logic [ALU_W-1:0] r_alu;
    logic             i_legal;
    logic [ALU_W-1:0] i_alu;
    logic             i_sz;
    logic             retire_c;
    logic             illegal_c;

    // Instruction class and ALU operation decode from the held IR fields
    always_comb begin
        is_rtype  = (op == OP_RTYPE);
        is_mem    = (op == OP_LW) || (op == OP_SW);
        is_branch = (op == OP_BEQ) || (op == OP_BNE);
        r_legal   = 1'b1;
        r_alu     = ALU_ADD;
        case (func)
            FN_ADD, FN_ADDU: r_alu = ALU_ADD;
            FN_SUB, FN_SUBU: r_alu = ALU_SUB;
            FN_AND:          r_alu = ALU_AND;
            FN_OR:           r_alu = ALU_OR;
            FN_XOR:          r_alu = ALU_XOR;
            FN_NOR:          r_alu = ALU_NOR;
            FN_SLT:          r_alu = ALU_SLT;
            FN_SLTU:         r_alu = ALU_SLTU;
            default:         r_legal = 1'b0;
        endcase
        i_legal = 1'b1;
        i_alu   = ALU_ADD;
        i_sz    = 1'b0;
        case (op)
            OP_ADDI, OP_ADDIU: begin i_alu = ALU_ADD;  i_sz = 1'b1; end
            OP_SLTI:           begin i_alu = ALU_SLT;  i_sz = 1'b1; end
            OP_SLTIU:          begin i_alu = ALU_SLTU; i_sz = 1'b1; end
            OP_ANDI:           i_alu = ALU_AND;
            OP_ORI:            i_alu = ALU_OR;
            OP_XORI:           i_alu = ALU_XOR;
            OP_LUI:            i_alu = ALU_LUI;
            default:           i_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle datapath controls
    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        SZEn       = 1'b0;
        AluOP      = ALU_ADD;
        retire_c   = 1'b0;
        illegal_c  = 1'b0;
        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM4;
                SZEn    = 1'b1;
                if (is_mem) begin
                    state_next = MEMADR;
                end else if (is_rtype && r_legal) begin
                    state_next = EXEC_R;
                end else if (is_branch) begin
                    state_next = BRANCH;
                end else if (i_legal) begin
                    state_next = EXEC_I;
                end else begin
                    state_next = FETCH;
                    illegal_c  = 1'b1;
                end
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                SZEn       = 1'b1;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                retire_c   = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                retire_c   = 1'b1;
                state_next = FETCH;
            end
            EXEC_R: begin
                ALUSrcA    = 1'b1;
                RegDst     = 1'b1;
                AluOP      = r_alu;
                state_next = ALUWB;
            end
            EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                SZEn       = i_sz;
                AluOP      = i_alu;
                state_next = ALUWB;
            end
            ALUWB: begin
                RegDst     = is_rtype;
                RegWrite   = 1'b1;
                retire_c   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                AluOP      = ALU_SUB;
                PCSrc      = 1'b1;
                PCWrite    = ((op == OP_BEQ) && AluZero) || ((op == OP_BNE) && !AluZero);
                retire_c   = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
        // Reset cycle: suppress every architectural write regardless of state
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            retire_c   = 1'b0;
            illegal_c  = 1'b0;
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            if (retire_c) begin
                retired <= retired + CNT_W'(1);
            end
            if (illegal_c) begin
                illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed, table-driven check of multi_cycle_ctrl: one record per clock cycle,
// plus a hand sequence that exercises the retired-counter wrap.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        AluZero;
    logic        PCWrite, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SZEn;
    logic [1:0]  ALUSrcB;
    logic [3:0]  AluOP;
    logic [31:0] retired;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .AluZero(AluZero),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .SZEn(SZEn), .AluOP(AluOP),
        .retired(retired), .illegal(illegal)
    );

    // Control word: PCWrite PCSrc IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB[1:0] SZEn AluOP[3:0]
    wire [15:0] ctl = {PCWrite, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                       ALUSrcA, ALUSrcB, SZEn, AluOP};

    localparam logic [15:0] C_FETCH  = 16'h8820;
    localparam logic [15:0] C_RSTF   = 16'h0020;
    localparam logic [15:0] C_DEC    = 16'h0070;
    localparam logic [15:0] C_MADR   = 16'h00D0;
    localparam logic [15:0] C_MRD    = 16'h2000;
    localparam logic [15:0] C_MWB    = 16'h0300;
    localparam logic [15:0] C_RSTMWR = 16'h2000;
    localparam logic [15:0] C_EXR    = 16'h0480;
    localparam logic [15:0] C_EXI_S  = 16'h00D0;
    localparam logic [15:0] C_WB_I   = 16'h0100;
    localparam logic [15:0] C_WB_R   = 16'h0500;
    localparam logic [15:0] C_BR_T   = 16'hC081;
    localparam logic [15:0] C_BR_N   = 16'h4081;
    localparam logic [15:0] C_ORI    = 16'h00C5;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        logic [15:0] ctl;
        logic [31:0] ret;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic [15:0] c, input logic [31:0] rt, input logic il);
        vec_t v;
        v.rst = r; v.op = o; v.func = f; v.zero = z; v.ctl = c; v.ret = rt; v.ill = il;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z);
        @(negedge clk);
        reset = r; op = o; func = f; AluZero = z;
        #1;
    endtask

    initial begin
        reset = 1'b1; op = '0; func = '0; AluZero = 1'b0;
        repeat (2) @(posedge clk);

        // Reset cycle in FETCH: write enables masked
        add_vec(1, 6'h00, 6'h00, 0, C_RSTF, 0, 0);
        // addi $1,$0,5
        add_vec(0, 6'h08, 6'h05, 0, C_FETCH, 0, 0);
        add_vec(0, 6'h08, 6'h05, 0, C_DEC,   0, 0);
        add_vec(0, 6'h08, 6'h05, 0, C_EXI_S, 0, 0);
        add_vec(0, 6'h08, 6'h05, 0, C_WB_I,  0, 0);
        // lw
        add_vec(0, 6'h23, 6'h04, 0, C_FETCH, 1, 0);
        add_vec(0, 6'h23, 6'h04, 0, C_DEC,   1, 0);
        add_vec(0, 6'h23, 6'h04, 0, C_MADR,  1, 0);
        add_vec(0, 6'h23, 6'h04, 0, C_MRD,   1, 0);
        add_vec(0, 6'h23, 6'h04, 0, C_MWB,   1, 0);
        // beq taken
        add_vec(0, 6'h04, 6'h00, 0, C_FETCH, 2, 0);
        add_vec(0, 6'h04, 6'h00, 0, C_DEC,   2, 0);
        add_vec(0, 6'h04, 6'h00, 1, C_BR_T,  2, 0);
        // beq not taken
        add_vec(0, 6'h04, 6'h00, 1, C_FETCH, 3, 0);
        add_vec(0, 6'h04, 6'h00, 1, C_DEC,   3, 0);
        add_vec(0, 6'h04, 6'h00, 0, C_BR_N,  3, 0);
        // add (R-type)
        add_vec(0, 6'h00, 6'h20, 0, C_FETCH, 4, 0);
        add_vec(0, 6'h00, 6'h20, 0, C_DEC,   4, 0);
        add_vec(0, 6'h00, 6'h20, 0, C_EXR,   4, 0);
        add_vec(0, 6'h00, 6'h20, 0, C_WB_R,  4, 0);
        // sub (R-type), AluOP=1
        add_vec(0, 6'h00, 6'h22, 0, C_FETCH, 5, 0);
        add_vec(0, 6'h00, 6'h22, 0, C_DEC,   5, 0);
        add_vec(0, 6'h00, 6'h22, 0, C_EXR | 16'h0001, 5, 0);
        add_vec(0, 6'h00, 6'h22, 0, C_WB_R,  5, 0);
        // bne with AluZero=0 is taken
        add_vec(0, 6'h05, 6'h00, 0, C_FETCH, 6, 0);
        add_vec(0, 6'h05, 6'h00, 0, C_DEC,   6, 0);
        add_vec(0, 6'h05, 6'h00, 0, C_BR_T,  6, 0);
        // illegal func, then illegal op: 2 cycles each, sticky flag
        add_vec(0, 6'h00, 6'h3F, 0, C_FETCH, 7, 0);
        add_vec(0, 6'h00, 6'h3F, 0, C_DEC,   7, 0);
        add_vec(0, 6'h3F, 6'h00, 0, C_FETCH, 7, 1);
        add_vec(0, 6'h3F, 6'h00, 0, C_DEC,   7, 1);
        // sw with reset landing in MEMWR
        add_vec(0, 6'h2B, 6'h00, 0, C_FETCH, 7, 1);
        add_vec(0, 6'h2B, 6'h00, 0, C_DEC,   7, 1);
        add_vec(0, 6'h2B, 6'h00, 0, C_MADR,  7, 1);
        add_vec(1, 6'h2B, 6'h00, 0, C_RSTMWR, 7, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].func, vecs[i].zero);
            check("ctl", i, 32'(ctl), 32'(vecs[i].ctl));
            check("retired", i, retired, vecs[i].ret);
            check("illegal", i, 32'(illegal), 32'(vecs[i].ill));
        end

        // After the aborted store: back in FETCH with counters cleared, then ori across the counter wrap
        drive(0, 6'h0D, 6'h00, 0);
        check("post_rst_ctl", 100, 32'(ctl), 32'(C_FETCH));
        check("post_rst_retired", 100, retired, 32'h0);
        check("post_rst_illegal", 100, 32'(illegal), 32'h0);
        force dut.retired = 32'hFFFF_FFFF;
        drive(0, 6'h0D, 6'h00, 0);
        release dut.retired;
        #1;
        check("ori_dec_ctl", 101, 32'(ctl), 32'(C_DEC));
        drive(0, 6'h0D, 6'h00, 0);
        check("ori_exec_ctl", 102, 32'(ctl), 32'(C_ORI));
        check("ori_preload", 102, retired, 32'hFFFF_FFFF);
        drive(0, 6'h0D, 6'h00, 0);
        check("ori_wb_ctl", 103, 32'(ctl), 32'(C_WB_I));
        drive(0, 6'h0D, 6'h00, 0);
        check("ori_wrap_retired", 104, retired, 32'h0);
        check("ori_next_fetch", 104, 32'(ctl), 32'(C_FETCH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
